// File: rtl/buffer_stream_pkg.sv
// rtl/buffer_stream_pkg.sv - shared types and constants for the buffer stream reader
//
// Purpose: state encoding, default widths, FIFO depth and the one's-complement
//          checksum step used by buffer_stream_reader and stream_skid_fifo.
// Ports:   none (package).

package buffer_stream_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int LEN_WIDTH_DEF  = 14;
   localparam int FIFO_DEPTH     = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Adds both halves of a 32-bit word into a 16-bit one's-complement
   // accumulator. Three 16-bit terms can carry up to 2 bits; two folds
   // are enough because the first fold leaves at most a 1-bit carry.
   function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [31:0] word);
      logic [17:0] sum;
      logic [16:0] fold;
      sum  = {2'b00, acc} + {2'b00, word[31:16]} + {2'b00, word[15:0]};
      fold = {1'b0, sum[15:0]} + {15'd0, sum[17:16]};
      return fold[15:0] + {15'd0, fold[16]};
   endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 3-entry first-word-fall-through FIFO
//
// Purpose: holds words returned by the buffer until the stream consumer
//          accepts them; the head entry is always visible on pop_data_o.
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   push_i            write push_data_i (ignored when full without a pop)
//   push_data_i       word to store
//   pop_i             discard head entry (ignored when empty)
//   pop_data_o        head entry
//   count_o           number of stored entries (0..3)

module stream_skid_fifo
   import buffer_stream_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [0:FIFO_DEPTH-1];
   logic [1:0]       wr_ptr_q;
   logic [1:0]       rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign do_pop  = pop_i && (count_q != 2'd0);
   assign do_push = push_i && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 2'd1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 2'd1;
         end
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

endmodule

// File: rtl/buffer_stream_reader.sv
// rtl/buffer_stream_reader.sv - drains len words from the buffer memory onto a valid/ready stream
//
// Purpose: on start_i reads exactly len_i words from the auto-addressed
//          buffer, hides its one-cycle read latency behind a 3-entry FIFO
//          and presents the words as a stream with m_last_o on the final one.
// Optional feature macro: BUFFER_STREAM_READER_CHECKSUM_EN adds checksum_o,
//          the running 16-bit one's-complement sum of accepted words.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   start_i, len_i      command pulse and word count (sampled in IDLE)
//   busy_o, done_o      transfer in progress / one-cycle completion pulse
//   buf_data_av_i       buffer holds unread data
//   buf_rd_en_o         read request (combinational)
//   buf_data_out_i      read data, valid the cycle after buf_rd_en_o
//   m_data_o, m_valid_o, m_ready_i, m_last_o   output stream
//   checksum_o          payload checksum (macro only)

module buffer_stream_reader
   import buffer_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  buf_data_av_i,
   output logic                  buf_rd_en_o,
   input  logic [DATA_WIDTH-1:0] buf_data_out_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  m_last_o
`ifdef BUFFER_STREAM_READER_CHECKSUM_EN
   ,
   output logic [15:0]           checksum_o
`endif
);

   state_e                state_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  inflight_q;
   logic [LEN_WIDTH-1:0]  rd_remaining_q, rd_remaining_d;
   logic [LEN_WIDTH-1:0]  out_remaining_q, out_remaining_d;
   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic [2:0]            credit_used;
   logic                  start_accept;
   logic                  xfer;

   assign start_accept = (state_q == ST_IDLE) && start_i;

   // A read is only issued when the FIFO can still absorb it after the
   // one-cycle buffer latency, so stalls on m_ready_i never drop data.
   assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q};
   assign buf_rd_en_o = (state_q == ST_READ) && buf_data_av_i &&
                        (rd_remaining_q != '0) && (credit_used < 3'(FIFO_DEPTH));

   assign m_valid_o = (fifo_count != 2'd0);
   assign m_data_o  = m_valid_o ? fifo_head : '0;
   assign m_last_o  = m_valid_o && (out_remaining_q == LEN_WIDTH'(1));
   assign xfer      = m_valid_o && m_ready_i;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

   stream_skid_fifo #(
      .WIDTH(DATA_WIDTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .push_i      (inflight_q),
      .push_data_i (buf_data_out_i),
      .pop_i       (xfer),
      .pop_data_o  (fifo_head),
      .count_o     (fifo_count)
   );

   always_comb begin
      rd_remaining_d  = rd_remaining_q;
      out_remaining_d = out_remaining_q;
      if (start_accept) begin
         rd_remaining_d  = len_i;
         out_remaining_d = len_i;
      end else begin
         if (buf_rd_en_o) begin
            rd_remaining_d = rd_remaining_q - LEN_WIDTH'(1);
         end
         if (xfer) begin
            out_remaining_d = out_remaining_q - LEN_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q         <= ST_IDLE;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         inflight_q      <= 1'b0;
         rd_remaining_q  <= '0;
         out_remaining_q <= '0;
      end else begin
         rd_remaining_q  <= rd_remaining_d;
         out_remaining_q <= out_remaining_d;
         inflight_q      <= buf_rd_en_o;
         done_q          <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  busy_q <= 1'b1;
                  if (len_i == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (rd_remaining_d == '0) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // The last word can only leave after all reads returned,
               // so its acceptance also means the FIFO is empty.
               if (xfer && m_last_o) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BUFFER_STREAM_READER_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (start_accept) begin
         checksum_d = 16'd0;
      end else if (xfer) begin
         checksum_d = csum_add(checksum_q, m_data_o);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         checksum_q <= 16'd0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum_o = checksum_q;
`endif

endmodule

// File: doc/buffer_stream_reader.md
# buffer_stream_reader

Downstream drain stage for the 32-bit auto-addressed buffer memory. On a `start` command it reads exactly `len` words out of the buffer via `buf_rd_en`/`buf_data_av`. It absorbs the buffer's one-cycle registered read latency and presents the words as a valid/ready stream with `m_last` on the final word. It feeds the packet transmit path (UDP/TCP payload), optionally computing the payload's one's-complement checksum on the fly.

## Interface
- `DATA_WIDTH`, 32, word width; must match buffer memory
- `LEN_WIDTH`, 14, width of `len`; matches buffer address counters
- `clk`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  one-cycle command pulse; sampled only in IDLE
- `len`  input  LEN_WIDTH  words to read; sampled with `start`
- `busy`  output  1  transfer in progress
- `done`  output  1  one-cycle pulse when transfer completes
- `buf_data_av`  input  1  buffer holds unread data
- `buf_rd_en`  output  1  read request to buffer (combinational)
- `buf_data_out`  input  DATA_WIDTH  buffer read data, valid the cycle after `buf_rd_en`
- `m_data`  output  DATA_WIDTH  stream data
- `m_valid`  output  1  stream data valid
- `m_ready`  input  1  downstream accepts
- `m_last`  output  1  marks final word
- `checksum`  output  16  payload checksum (only with macro)

## Operation
- Reset values:
  - `busy`, `done`, `buf_rd_en`, `m_valid`, `m_last` = 0
  - `m_data` = 0, `checksum` = 0
  - state = IDLE
  - all counters and the FIFO are cleared
- States:
  - IDLE: on `start` with `len`≠0, latch `len` into `rd_remaining` and `out_remaining`, then go to READ. With `len`=0, go to DONE.
  - READ: issue reads; when `rd_remaining` reaches 0, go to DRAIN.
  - DRAIN: wait for the FIFO to empty and the final word to be accepted; then go to DONE.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- `buf_rd_en` = (state==READ) && `buf_data_av` && `rd_remaining`≠0 && (fifo_count + inflight) < 3.
  - Each asserted read decrements `rd_remaining`.
  - The read sets the `inflight` flag for one cycle, so `buf_data_out` is written into the FIFO on the next edge.
- Never read with `buf_data_av`=0; the buffer is never underflowed.
- Stream handshake:
  - A word transfers on `m_valid && m_ready`.
  - `m_data`, `m_valid` and `m_last` hold stable while `m_valid && !m_ready`.
  - Each transfer decrements `out_remaining`.
  - `m_last` = `m_valid` && `out_remaining`==1.
- `busy` = 1 in READ, DRAIN and DONE; 0 in IDLE.
- `start` is ignored while not in IDLE.
- Reset asserted mid-transfer aborts immediately to reset values. Any word already read from the buffer is lost; the buffer's own counters are not rewound.

## Timing
- `start` high in cycle 0 gives:
  - READ in cycle 1, with `buf_rd_en` possible in cycle 1
  - data captured in the FIFO at the end of cycle 2
  - earliest `m_valid` in cycle 3
- With `buf_data_av` and `m_ready` held high, throughput is one word per cycle.
- `done` is asserted in the cycle after the `m_last` transfer.
- `len`=0: `done` is pulsed in cycle 1, with no reads and no `m_valid`.
- When `m_ready` is low, reads stop once the 3-deep FIFO plus in-flight credit is exhausted. No data is dropped.
- When `buf_data_av` drops mid-transfer, the block stalls in READ with no timeout and resumes when it rises.

## Configuration
- Macro: `BUFFER_STREAM_READER_CHECKSUM_EN`.
- Defined:
  - `checksum` port exists.
  - On every accepted word, `checksum` accumulates the 16-bit one's-complement sum of `m_data[31:16]` and `m_data[15:0]`, with end-around carry folded each cycle.
  - `checksum` clears to 0 when `start` is accepted.
  - The final value is valid in the `done` cycle and holds until the next `start`.
  - The value is the raw sum, not inverted.
- Undefined: no port and no adder logic; all other behaviour is identical.

## Structure
- Shared package `buffer_stream_pkg` holds:
  - state encoding: IDLE=0, READ=1, DRAIN=2, DONE=3
  - `DATA_WIDTH`/`LEN_WIDTH` defaults
  - FIFO depth constant 3
- One sub-module, `stream_skid_fifo`:
  - 3-entry synchronous FIFO with first-word fall-through
  - push/pop/count interface
  - asynchronous reset

## Test plan
- `len`=4, buffer preloaded with 0x11111111..0x44444444, `m_ready`=1 → `m_valid` cycles 3–6 in order, `m_last` only on 0x44444444, `done` in cycle 7.
- `len`=0 → `done` in cycle 1, `buf_rd_en` and `m_valid` never asserted.
- `len`=8, `m_ready` toggling 1010… → 8 words in order, none duplicated or dropped, `m_data` stable while stalled, and fifo_count + inflight never exceeds 3.
- `len`=6, buffer holding 2 words, remaining 4 written 10 cycles later → stall with `buf_rd_en`=0 while `buf_data_av`=0, then completes with exactly 6 words.
- Reset pulsed after the 3rd of 8 words → all outputs at reset values asynchronously; a subsequent `start` with `len`=2 behaves normally.
- With macro, words 0xFFFF0001 and 0x00010000 → `checksum`=0x0002 in the `done` cycle, cleared at the next `start`.
